// File: rtl/branch_pkg.sv
// Shared types for the branch fan-out stage.
package branch_pkg;

    // Routing mode applied to the beat being accepted.
    typedef enum logic [1:0] {
        MODE_BCAST = 2'd0,
        MODE_RR    = 2'd1,
        MODE_MASK  = 2'd2,
        MODE_RSVD  = 2'd3
    } branch_mode_e;

endpackage

// File: rtl/branch_chan_fifo.sv
// Per-channel output FIFO with a registered head.
// The head register keeps the last popped value while the FIFO is empty.
module branch_chan_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] rd_next;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push;
    logic             do_pop;

    // Full/empty come from the registered count only: a pop never frees room
    // for a push in the same cycle.
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign do_push   = push && !full;
    assign do_pop    = out_ready && !empty;
    assign rd_next   = rd_ptr_q + 1'b1;
    assign out_valid = !empty;
    assign out_data  = head_q;

    // Next pointers, occupancy and head value.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_next;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Head tracks the oldest entry; with nothing left it keeps the popped beat.
        if (do_pop) begin
            if (count_q > CW'(1)) begin
                head_d = mem_q[rd_next];
            end else if (do_push) begin
                head_d = push_data;
            end
        end else if (empty && do_push) begin
            head_d = push_data;
        end
    end

    // Storage array, written at the tail; never reset, only head is visible.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Control state and head register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/branch_rho.sv
// N-way branch stage: one valid/ready input fanned out to NUM_OUT buffered
// channels with broadcast, round-robin or mask routing per beat.
module branch_rho
    import branch_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NUM_OUT = 4,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 mode,
    input  logic [NUM_OUT-1:0]         mask,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic [NUM_OUT-1:0]         out_valid,
    input  logic [NUM_OUT-1:0]         out_ready,
    output logic [NUM_OUT*WIDTH-1:0]   out_data,
    output logic [$clog2(NUM_OUT)-1:0] rr_ptr,
    output logic [CNT_W-1:0]           accept_cnt
);

    localparam int RR_W = $clog2(NUM_OUT);
    localparam logic [RR_W-1:0] RR_LAST = RR_W'(NUM_OUT - 1);

    branch_mode_e       mode_e;
    logic [NUM_OUT-1:0] target;
    logic [NUM_OUT-1:0] chan_full;
    logic [NUM_OUT-1:0] chan_empty;
    logic [NUM_OUT-1:0] chan_ok;
    logic [NUM_OUT-1:0] chan_push;
    logic               accept;
    logic [RR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   accept_cnt_q, accept_cnt_d;

    assign mode_e = branch_mode_e'(mode);

    // Decode the target set for the beat currently offered.
    always_comb begin
        target = '0;
        case (mode_e)
            MODE_BCAST: target = '1;
            MODE_RR:    target[rr_ptr_q] = 1'b1;
            MODE_MASK:  target = mask;
            default:    target = '0;
        endcase
    end

    // A beat is taken only when every targeted channel has room, so the
    // broadcast is all-or-nothing; an empty target set holds the beat upstream.
    assign in_ready = !rst && (target != '0) && (&chan_ok);
    assign accept   = in_valid && in_ready;

    generate
        for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_chan
            assign chan_ok[gi]   = !target[gi] || !chan_full[gi];
            assign chan_push[gi] = accept && target[gi];

            branch_chan_fifo #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH)
            ) u_fifo (
                .clk       (clk),
                .rst       (rst),
                .push      (chan_push[gi]),
                .push_data (in_data),
                .out_ready (out_ready[gi]),
                .out_valid (out_valid[gi]),
                .out_data  (out_data[gi*WIDTH +: WIDTH]),
                .full      (chan_full[gi]),
                .empty     (chan_empty[gi])
            );
        end
    endgenerate

    // Round-robin pointer advances only on round-robin accepts; counter on every accept.
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        accept_cnt_d = accept_cnt_q;
        if (accept) begin
            accept_cnt_d = accept_cnt_q + 1'b1;
            if (mode_e == MODE_RR) begin
                rr_ptr_d = (rr_ptr_q == RR_LAST) ? '0 : rr_ptr_q + 1'b1;
            end
        end
    end

    // Status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= '0;
            accept_cnt_q <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            accept_cnt_q <= accept_cnt_d;
        end
    end

    assign rr_ptr     = rr_ptr_q;
    assign accept_cnt = accept_cnt_q;

endmodule

// File: tb/tb_branch_rho.sv
// Bench for branch_rho: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a queue-based model.
module tb_branch_rho;
    import branch_pkg::*;

    localparam int WIDTH   = 32;
    localparam int NUM_OUT = 4;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MOD = 1 << CNT_W;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [1:0]               mode;
    logic [NUM_OUT-1:0]       mask;
    logic                     in_valid;
    logic                     in_ready;
    logic [WIDTH-1:0]         in_data;
    logic [NUM_OUT-1:0]       out_valid;
    logic [NUM_OUT-1:0]       out_ready;
    logic [NUM_OUT*WIDTH-1:0] out_data;
    logic [1:0]               rr_ptr;
    logic [CNT_W-1:0]         accept_cnt;

    int checks = 0;
    int errors = 0;

    branch_rho #(
        .WIDTH   (WIDTH),
        .NUM_OUT (NUM_OUT),
        .DEPTH   (DEPTH),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .mask       (mask),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .rr_ptr     (rr_ptr),
        .accept_cnt (accept_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [WIDTH-1:0] mq [NUM_OUT][$];
    logic [WIDTH-1:0] lastpop [NUM_OUT];
    int m_rr  = 0;
    int m_cnt = 0;
    bit model_ok = 0;

    function automatic logic [NUM_OUT-1:0] m_targets();
        case (mode)
            2'd0:    return '1;
            2'd1:    return NUM_OUT'(1) << m_rr;
            2'd2:    return mask;
            default: return '0;
        endcase
    endfunction

    function automatic bit m_ready();
        logic [NUM_OUT-1:0] t;
        if (rst) return 0;
        t = m_targets();
        if (t == '0) return 0;
        for (int c = 0; c < NUM_OUT; c++)
            if (t[c] && mq[c].size() >= DEPTH) return 0;
        return 1;
    endfunction

    // Advance the model on each edge using the inputs present at that edge.
    always @(posedge clk) begin
        logic [NUM_OUT-1:0] t;
        bit acc;
        if (rst) begin
            for (int c = 0; c < NUM_OUT; c++) begin
                mq[c].delete();
                lastpop[c] = '0;
            end
            m_rr = 0;
            m_cnt = 0;
            model_ok = 1;
        end else if (model_ok) begin
            acc = in_valid && m_ready();
            t = m_targets();
            for (int c = 0; c < NUM_OUT; c++)
                if (mq[c].size() > 0 && out_ready[c]) lastpop[c] = mq[c].pop_front();
            if (acc) begin
                for (int c = 0; c < NUM_OUT; c++)
                    if (t[c]) mq[c].push_back(in_data);
                m_cnt = (m_cnt + 1) % CNT_MOD;
                if (mode == MODE_RR) m_rr = (m_rr + 1) % NUM_OUT;
            end
        end
    end

    // Per-cycle comparison, sampled mid-cycle; also collects channel-2 pops.
    bit collect_en = 0;
    logic [WIDTH-1:0] col2 [$];
    always @(negedge clk) begin
        logic [NUM_OUT-1:0]       e_ov;
        logic [NUM_OUT*WIDTH-1:0] e_od;
        if (model_ok) begin
            for (int c = 0; c < NUM_OUT; c++) begin
                e_ov[c] = mq[c].size() > 0;
                e_od[c*WIDTH +: WIDTH] = (mq[c].size() > 0) ? mq[c][0] : lastpop[c];
            end
            chk("cyc_in_ready", 128'(in_ready), 128'(m_ready()));
            chk("cyc_out_valid", 128'(out_valid), 128'(e_ov));
            chk("cyc_out_data", 128'(out_data), 128'(e_od));
            chk("cyc_rr_ptr", 128'(rr_ptr), 128'(m_rr));
            chk("cyc_accept_cnt", 128'(accept_cnt), 128'(m_cnt));
        end
        if (collect_en && out_valid[2] && out_ready[2]) col2.push_back(out_data[2*WIDTH +: WIDTH]);
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [WIDTH-1:0] d);
        bit acc = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        chk("send_accept_timeout", 128'(acc), 128'(1));
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_rr [5];
        bit acc;
        exp_rr = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        // 1. reset with a pending beat
        rst = 1'b1; mode = 2'd0; mask = '0; in_valid = 1'b1; in_data = 32'hFFFF_FFFF; out_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(4'b0000));
        chk("rst_rr_ptr", 128'(rr_ptr), 128'(0));
        chk("rst_accept_cnt", 128'(accept_cnt), 128'(0));
        chk("rst_out_data", 128'(out_data), 128'(0));
        rst = 1'b0; in_valid = 1'b0;
        idle(1);

        // 2. broadcast one beat, then wrap the 4-bit counter
        mode = 2'd0; out_ready = 4'hF;
        send(32'hA5A5_0001);
        chk("bcast_out_valid", 128'(out_valid), 128'(4'hF));
        chk("bcast_head0", 128'(out_data[0 +: WIDTH]), 128'(32'hA5A5_0001));
        chk("bcast_head3", 128'(out_data[3*WIDTH +: WIDTH]), 128'(32'hA5A5_0001));
        chk("bcast_cnt1", 128'(accept_cnt), 128'(1));
        for (int i = 1; i < 16; i++) send(32'hB000_0000 + 32'(i));
        chk("bcast_cnt_wrap", 128'(accept_cnt), 128'(0));
        idle(3);

        // 3. round-robin beats 1..5
        mode = 2'd1;
        chk("rr_start", 128'(rr_ptr), 128'(0));
        for (int i = 0; i < 5; i++) begin
            send(32'(i + 1));
            chk("rr_ptr_step", 128'(rr_ptr), 128'(exp_rr[i]));
            chk("rr_valid_step", 128'(out_valid), 128'(4'b0001 << (i % 4)));
            chk("rr_head_step", 128'(out_data[(i % 4)*WIDTH +: WIDTH]), 128'(i + 1));
        end
        idle(3);

        // 4. broadcast into a stalled channel 2
        mode = 2'd0; out_ready = 4'b1011; col2.delete(); collect_en = 1;
        for (int i = 0; i < 4; i++) send(32'h10 + 32'(i));
        in_valid = 1'b1; in_data = 32'h14;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("stall_in_ready", 128'(in_ready), 128'(0));
            chk("stall_head2", 128'(out_data[2*WIDTH +: WIDTH]), 128'(32'h10));
            chk("stall_valid2", 128'(out_valid[2]), 128'(1));
            @(posedge clk);
            #1;
        end
        out_ready = 4'hF;
        send(32'h14);
        send(32'h15);
        idle(8);
        collect_en = 0;
        chk("stall_col2_len", 128'(col2.size()), 128'(6));
        for (int i = 0; i < 6 && i < col2.size(); i++)
            chk("stall_col2_order", 128'(col2[i]), 128'(32'h10 + i));

        // 5. mask routing and empty target sets
        mode = 2'd2; mask = 4'b0101; out_ready = 4'h0;
        send(32'hDEAD_BEEF);
        chk("mask_valid", 128'(out_valid), 128'(4'b0101));
        chk("mask_head2", 128'(out_data[2*WIDTH +: WIDTH]), 128'(32'hDEAD_BEEF));
        mask = 4'b0000; in_valid = 1'b1; in_data = 32'h1234;
        repeat (2) @(posedge clk);
        #1;
        chk("mask0_in_ready", 128'(in_ready), 128'(0));
        chk("mask0_cnt", 128'(accept_cnt), 128'(12));
        mode = 2'd3; mask = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        chk("rsvd_in_ready", 128'(in_ready), 128'(0));
        chk("rsvd_cnt", 128'(accept_cnt), 128'(12));
        in_valid = 1'b0; out_ready = 4'hF;
        idle(3);

        // 6. mid-operation reset with channel 1 holding beats
        mode = 2'd1; out_ready = 4'b1101;
        for (int i = 0; i < 9; i++) send(32'h60 + 32'(i));
        chk("fill_valid1", 128'(out_valid[1]), 128'(1));
        chk("fill_head1", 128'(out_data[WIDTH +: WIDTH]), 128'(32'h60));
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_rr", 128'(rr_ptr), 128'(0));
        chk("mid_rst_cnt", 128'(accept_cnt), 128'(0));
        chk("mid_rst_in_ready", 128'(in_ready), 128'(0));
        rst = 1'b0;
        out_ready = 4'h0;
        send(32'h77);
        chk("post_rst_valid", 128'(out_valid), 128'(4'b0001));
        chk("post_rst_head0", 128'(out_data[0 +: WIDTH]), 128'(32'h77));
        chk("post_rst_cnt", 128'(accept_cnt), 128'(1));
        out_ready = 4'hF;
        idle(3);

        // Randomized phase: upstream holds a beat until it is accepted.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 299) == 0);
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = $urandom;
            end
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) out_ready = 4'($urandom_range(0, 15));
            else out_ready = 4'($urandom_range(0, 15) | $urandom_range(0, 15));
        end
        rst = 1'b0; out_ready = 4'hF;
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
